// File: rtl/purifier_pkg.sv
// Shared types, defaults and demand-priority helper for the purifier fan controller.
package purifier_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        MAX  = 2'd3
    } speed_e;

    localparam int DEB_CYC_DEF  = 4;
    localparam int HOLD_CYC_DEF = 8;

    // Override beats pollution, pollution beats sleep.
    function automatic speed_e demand_f(input logic i_override,
                                        input logic i_any_qual,
                                        input logic i_sleep);
        if (i_override)      return MAX;
        else if (i_any_qual) return HIGH;
        else if (i_sleep)    return LOW;
        else                 return OFF;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Single-sensor debouncer: saturating count of consecutive high samples.
module sensor_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sens,
    output logic o_qual
);
    localparam int W = $clog2(DEB_CYC + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)                 r_cnt <= '0;
        else if (!i_sens)             r_cnt <= '0;
        else if (r_cnt != W'(DEB_CYC)) r_cnt <= r_cnt + W'(1);
    end

    assign o_qual = (r_cnt == W'(DEB_CYC));

endmodule

// File: rtl/purifier_fan_ctrl.sv
// Fan-speed controller: debounced sensors, priority demand, hold-before-downshift FSM.
module purifier_fan_ctrl
    import purifier_pkg::*;
#(
    parameter int N_SENS   = 2,
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SENS-1:0] sens_i,
    input  logic              sleep_i,
    input  logic              override_i,
    output logic              f_low_o,
    output logic              f_high_o,
    output logic [1:0]        state_o,
    output logic              alarm_o
);
    localparam int CNT_W = $clog2(((DEB_CYC > HOLD_CYC) ? DEB_CYC : HOLD_CYC) + 1);

    logic [N_SENS-1:0] w_qual;
    logic              w_any_qual;
    speed_e            w_demand;
    speed_e            r_state;
    speed_e            w_state_nxt;
    logic [CNT_W-1:0]  r_hold_cnt;
    logic [CNT_W-1:0]  w_hold_nxt;
    logic [CNT_W-1:0]  w_hold_inc;
    logic              r_alarm;

    for (genvar k = 0; k < N_SENS; k++) begin : g_deb
        sensor_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_sens  (sens_i[k]),
            .o_qual  (w_qual[k])
        );
    end

    assign w_any_qual = |w_qual;
    assign w_demand   = demand_f(override_i, w_any_qual, sleep_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= OFF;
            r_hold_cnt <= '0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_alarm    <= w_any_qual;
        end
    end

    // Upshifts are immediate; downshifts jump straight to the demand once the hold expires.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = '0;
        w_hold_inc  = r_hold_cnt + CNT_W'(1);
        if (w_demand > r_state) begin
            w_state_nxt = w_demand;
        end else if (w_demand < r_state) begin
            if ((HOLD_CYC == 0) || (w_hold_inc == CNT_W'(HOLD_CYC)))
                w_state_nxt = w_demand;
            else
                w_hold_nxt = w_hold_inc;
        end
    end

    always_comb begin
        f_low_o  = 1'b0;
        f_high_o = 1'b0;
        case (r_state)
            LOW:       f_low_o  = 1'b1;
            HIGH, MAX: f_high_o = 1'b1;
            default:   ;
        endcase
    end

    assign state_o = r_state;
    assign alarm_o = r_alarm;

endmodule
